// File: rtl/vga_timing_pkg.sv
// Shared raster timing types, standard mode presets and helpers for vga_timing_gen.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480 = '{
    h: '{active: 640, front: 16, sync: 96,  back: 48},
    v: '{active: 480, front: 10, sync: 2,   back: 33}
  };

  localparam vga_timing_t SVGA_800x600 = '{
    h: '{active: 800, front: 40, sync: 128, back: 88},
    v: '{active: 600, front: 1,  sync: 4,   back: 23}
  };

  function automatic int unsigned total(input axis_timing_t t);
    return t.active + t.front + t.sync + t.back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: wrapping position counter with look-ahead active/sync decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter axis_timing_t T       = VGA_640x480.h,
  parameter bit           POL     = 1'b0,
  parameter int unsigned  CW      = 11,
  parameter int unsigned  RST_VAL = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_next_c,
  output logic          last_c,
  output logic          active_next_c,
  output logic          sync_next_c
);

  localparam int unsigned TOTAL   = total(T);
  localparam int unsigned SYNC_LO = T.active + T.front;
  localparam int unsigned SYNC_HI = SYNC_LO + T.sync;

  logic [31:0] nxt_w;

  // Decodes use the post-edge position so registered consumers line up with cnt
  always_comb begin
    last_c     = (cnt == CW'(TOTAL - 1));
    cnt_next_c = cnt;
    if (adv) cnt_next_c = last_c ? '0 : cnt + CW'(1);
    nxt_w         = 32'(cnt_next_c);
    active_next_c = (nxt_w < T.active);
    sync_next_c   = ((nxt_w >= SYNC_LO) && (nxt_w < SYNC_HI)) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= CW'(RST_VAL);
    else          cnt <= cnt_next_c;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel-clock divider and enable/hold.
// Optional fetch-ahead position outputs when VGA_TIMING_PREFETCH_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h.active,
  parameter int unsigned H_FRONT  = VGA_640x480.h.front,
  parameter int unsigned H_SYNC   = VGA_640x480.h.sync,
  parameter int unsigned H_BACK   = VGA_640x480.h.back,
  parameter int unsigned V_ACTIVE = VGA_640x480.v.active,
  parameter int unsigned V_FRONT  = VGA_640x480.v.front,
  parameter int unsigned V_SYNC   = VGA_640x480.v.sync,
  parameter int unsigned V_BACK   = VGA_640x480.v.back,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
`ifdef VGA_TIMING_PREFETCH_EN
  , parameter int unsigned PREFETCH = 4
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  output logic          pixel_tick,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_on,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  , output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid
`endif
);

  localparam axis_timing_t H_CFG = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
  localparam axis_timing_t V_CFG = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};
  localparam int unsigned H_TOTAL = total(H_CFG);
  localparam int unsigned V_TOTAL = total(V_CFG);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if ((64'(H_TOTAL) > (64'(1) << CW)) || (64'(V_TOTAL) > (64'(1) << CW))) begin : g_cw_err
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_div_err
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] div_q, div_nxt;
  logic          tick_q, tick_nxt;
  logic          adv_c, v_adv_c;
  logic          line_q, frame_q;
  logic          h_last_c, v_last_unused;
  logic [CW-1:0] x_nxt, y_nxt;
  logic          h_act_nxt, v_act_nxt, h_sync_nxt, v_sync_nxt;

  // Strobes and tick are qualified by enable so a hold never shows a stale pulse
  assign adv_c       = tick_q & enable;
  assign v_adv_c     = adv_c & h_last_c;
  assign pixel_tick  = adv_c;
  assign line_start  = line_q & enable;
  assign frame_start = frame_q & enable;

  always_comb begin
    div_nxt  = div_q;
    tick_nxt = tick_q;
    if (enable) begin
      div_nxt  = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
      tick_nxt = (div_nxt == DW'(CLK_DIV - 1));
    end
  end

  vga_axis_counter #(.T(H_CFG), .POL(HS_POL), .CW(CW), .RST_VAL(H_TOTAL - 1)) u_h (
    .clk(clk), .reset_n(reset_n), .adv(adv_c),
    .cnt(pixel_x), .cnt_next_c(x_nxt), .last_c(h_last_c),
    .active_next_c(h_act_nxt), .sync_next_c(h_sync_nxt)
  );

  vga_axis_counter #(.T(V_CFG), .POL(VS_POL), .CW(CW), .RST_VAL(V_TOTAL - 1)) u_v (
    .clk(clk), .reset_n(reset_n), .adv(v_adv_c),
    .cnt(pixel_y), .cnt_next_c(y_nxt), .last_c(v_last_unused),
    .active_next_c(v_act_nxt), .sync_next_c(v_sync_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      tick_q   <= 1'b0;
      video_on <= 1'b0;
      h_sync   <= ~HS_POL;
      v_sync   <= ~VS_POL;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      div_q    <= div_nxt;
      tick_q   <= tick_nxt;
      video_on <= h_act_nxt & v_act_nxt;
      h_sync   <= h_sync_nxt;
      v_sync   <= v_sync_nxt;
      line_q   <= tick_nxt & (x_nxt == '0);
      frame_q  <= tick_nxt & (x_nxt == '0) & (y_nxt == '0);
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  // Fetch position starts PREFETCH ticks ahead of the reset position and advances in lockstep
  localparam int unsigned F_LIN = H_TOTAL - 1 + PREFETCH;
  localparam int unsigned FX0   = F_LIN % H_TOTAL;
  localparam int unsigned FY0   = (V_TOTAL - 1 + F_LIN / H_TOTAL) % V_TOTAL;
  localparam bit          FV0   = (FX0 < H_ACTIVE) && (FY0 < V_ACTIVE);

  if ((PREFETCH < 1) || (PREFETCH > H_TOTAL - 1)) begin : g_pf_err
    $error("vga_timing_gen: PREFETCH out of range");
  end

  logic          fx_last_c, fy_last_unused;
  logic          fx_act_nxt, fy_act_nxt, fx_sync_unused, fy_sync_unused;
  logic [CW-1:0] fx_nxt_unused, fy_nxt_unused;

  vga_axis_counter #(.T(H_CFG), .POL(HS_POL), .CW(CW), .RST_VAL(FX0)) u_fx (
    .clk(clk), .reset_n(reset_n), .adv(adv_c),
    .cnt(fetch_x), .cnt_next_c(fx_nxt_unused), .last_c(fx_last_c),
    .active_next_c(fx_act_nxt), .sync_next_c(fx_sync_unused)
  );

  vga_axis_counter #(.T(V_CFG), .POL(VS_POL), .CW(CW), .RST_VAL(FY0)) u_fy (
    .clk(clk), .reset_n(reset_n), .adv(adv_c & fx_last_c),
    .cnt(fetch_y), .cnt_next_c(fy_nxt_unused), .last_c(fy_last_unused),
    .active_next_c(fy_act_nxt), .sync_next_c(fy_sync_unused)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fetch_valid <= FV0;
    else          fetch_valid <= fx_act_nxt & fy_act_nxt;
  end
`endif

endmodule
